// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions.
// Register file geometry, HLT opcode, index type.
package mips32_pkg;

  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  localparam logic [5:0] OP_HLT = 6'h3F;

  typedef logic [REG_AW-1:0] reg_idx_t;

endpackage

// File: rtl/mips32_hazard_scoreboard_if.sv
// Decode-to-scoreboard issue handshake.
// Decode is the master, scoreboard the slave.
interface mips32_hazard_scoreboard_if;
  import mips32_pkg::*;

  logic     issue_valid;
  reg_idx_t issue_src_a;
  reg_idx_t issue_src_b;
  logic     issue_use_a;
  logic     issue_use_b;
  logic     issue_wr;
  reg_idx_t issue_dst;
  logic     issue_halt;
  logic     issue_ready;

  modport master (
    output issue_valid,
    output issue_src_a,
    output issue_src_b,
    output issue_use_a,
    output issue_use_b,
    output issue_wr,
    output issue_dst,
    output issue_halt,
    input  issue_ready
  );

  modport slave (
    input  issue_valid,
    input  issue_src_a,
    input  issue_src_b,
    input  issue_use_a,
    input  issue_use_b,
    input  issue_wr,
    input  issue_dst,
    input  issue_halt,
    output issue_ready
  );

endinterface

// File: rtl/mips32_sb_counter.sv
// One pending-write countdown for a register.
// Clear beats load; load beats decrement.
module mips32_sb_counter #(
  parameter int CNT_W    = 3,
  parameter int LOAD_VAL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  output logic [CNT_W-1:0] cnt
);

  // count down to zero, reload on a new write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mips32_hazard_scoreboard.sv
// In-order issue scoreboard: RAW stall, HLT drain, flush.
// Define SCOREBOARD_FWD_EN to let EX/MEM bypass cover the last cycle.
module mips32_hazard_scoreboard #(
  parameter int NREGS  = mips32_pkg::NREGS,
  parameter int REG_AW = mips32_pkg::REG_AW,
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips32_hazard_scoreboard_if.slave issue,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec,
  output logic                  drained,
  output logic                  halted,
  output logic [15:0]           stall_cnt
);
  import mips32_pkg::*;

`ifdef SCOREBOARD_FWD_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic [NREGS-1:0][CNT_W-1:0] cnt;

  logic [REG_AW-1:0] src_a;
  logic [REG_AW-1:0] src_b;
  logic [REG_AW-1:0] dst;

  logic hz_a;
  logic hz_b;
  logic ready;
  logic fire;
  logic wr_en;
  logic stall;

  assign src_a = REG_AW'(issue.issue_src_a);
  assign src_b = REG_AW'(issue.issue_src_b);
  assign dst   = REG_AW'(issue.issue_dst);

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    logic ld;
    assign ld = wr_en & (dst == REG_AW'(r));
    mips32_sb_counter #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (WB_LAT)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .load  (ld),
      .cnt   (cnt[r])
    );
  end

  // per-register busy flags and drain status
  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < NREGS; r++) begin
      busy_vec[r] = |cnt[r];
    end
    drained = ~|busy_vec;
  end

  // source hazards against pre-edge counters
  always_comb begin
    hz_a = issue.issue_use_a
         & (src_a != '0)
         & (cnt[src_a] > CNT_W'(H));
    hz_b = issue.issue_use_b
         & (src_b != '0)
         & (cnt[src_b] > CNT_W'(H));
    ready = ~halted & ~hz_a & ~hz_b;
  end

  assign issue.issue_ready = ready;

  assign fire  = issue.issue_valid & ready;
  assign wr_en = fire & issue.issue_wr
               & (dst != '0);
  assign stall = issue.issue_valid & ~ready
               & ~halted;

  // latch HLT acceptance until flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (flush) begin
      halted <= 1'b0;
    end else if (fire & issue.issue_halt) begin
      halted <= 1'b1;
    end
  end

  // saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mips32_hazard_scoreboard.sv
// Directed scoreboard bench for mips32_hazard_scoreboard.
// Expected stall counts queue on drive, pop on fire.
module tb_mips32_hazard_scoreboard;
  import mips32_pkg::*;

  localparam int WB_LAT = 3;
`ifdef SCOREBOARD_FWD_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] busy_vec;
  logic        drained;
  logic        halted;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  mips32_hazard_scoreboard_if sb_if ();

  mips32_hazard_scoreboard #(
    .NREGS  (32),
    .REG_AW (5),
    .WB_LAT (WB_LAT),
    .CNT_W  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (sb_if),
    .flush     (flush),
    .busy_vec  (busy_vec),
    .drained   (drained),
    .halted    (halted),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input int a, input int ua,
                       input int b, input int ub,
                       input int wr, input int dst,
                       input int halt);
    sb_if.issue_src_a = 5'(a);
    sb_if.issue_use_a = ua[0];
    sb_if.issue_src_b = 5'(b);
    sb_if.issue_use_b = ub[0];
    sb_if.issue_wr    = wr[0];
    sb_if.issue_dst   = 5'(dst);
    sb_if.issue_halt  = halt[0];
    sb_if.issue_valid = 1'b1;
  endtask

  task automatic idle();
    sb_if.issue_valid = 1'b0;
    sb_if.issue_src_a = '0;
    sb_if.issue_src_b = '0;
    sb_if.issue_use_a = 1'b0;
    sb_if.issue_use_b = 1'b0;
    sb_if.issue_wr    = 1'b0;
    sb_if.issue_dst   = '0;
    sb_if.issue_halt  = 1'b0;
  endtask

  task automatic issue(input string tag,
                       input int a, input int ua,
                       input int b, input int ub,
                       input int wr, input int dst,
                       input int halt,
                       input int exp_stall);
    int st;
    bit ok;
    st = 0;
    ok = 1'b0;
    exp_q.push_back(exp_stall);
    drive(a, ua, b, ub, wr, dst, halt);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb_if.issue_ready) begin
        ok = 1'b1;
        break;
      end
      st++;
    end
    @(posedge clk);
    #1;
    sb_if.issue_valid = 1'b0;
    chk({tag, " fired"}, 32'(ok), 32'd1);
    chk({tag, " stalls"}, 32'(st),
        32'(exp_q.pop_front()));
  endtask

  task automatic drain(input string tag,
                       input int exp_n);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (drained) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    chk({tag, " drained"}, 32'(ok), 32'd1);
    if (exp_n >= 0)
      chk({tag, " drain cyc"}, 32'(n),
          32'(exp_n));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", busy_vec, 32'h0);
    chk("rst drained", 32'(drained), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post busy", busy_vec, 32'h0);
    chk("post drained", 32'(drained), 32'd1);
    chk("post ready",
        32'(sb_if.issue_ready), 32'd1);
    chk("post stall", 32'(stall_cnt), 32'd0);
    chk("post halted", 32'(halted), 32'd0);
    @(posedge clk);
    #1;

    issue("addi r1", 0, 1, 0, 0, 1, 1, 0, 0);
    issue("add r4", 1, 1, 2, 1, 1, 4, 0,
          WB_LAT - H);
    chk("raw busy", busy_vec, 32'h10);
    chk("raw stall_cnt", 32'(stall_cnt),
        32'(WB_LAT - H));
    drain("raw", WB_LAT);
    pulse_flush();
    chk("flush stall_cnt", 32'(stall_cnt),
        32'd0);

    issue("ind r1", 0, 1, 0, 1, 1, 1, 0, 0);
    issue("ind r2", 0, 1, 0, 1, 1, 2, 0, 0);
    issue("ind r3", 0, 1, 0, 1, 1, 3, 0, 0);
    chk("ind busy", busy_vec, 32'h0000000E);
    chk("ind stall_cnt", 32'(stall_cnt),
        32'd0);
    drain("ind", WB_LAT);

    issue("r0 wr", 0, 1, 0, 0, 1, 0, 0, 0);
    chk("r0 busy a", busy_vec, 32'h0);
    issue("r0 rd", 0, 1, 0, 1, 1, 0, 0, 0);
    chk("r0 busy b", busy_vec, 32'h0);

    issue("waw 1", 0, 0, 0, 0, 1, 5, 0, 0);
    issue("waw 2", 0, 0, 0, 0, 1, 5, 0, 0);
    issue("nouse", 5, 0, 5, 0, 0, 0, 0, 0);
    issue("waw rd", 0, 0, 5, 1, 1, 8, 0,
          WB_LAT - 1 - H);
    chk("waw stall_cnt", 32'(stall_cnt),
        32'(WB_LAT - 1 - H));
    drain("waw", -1);

    issue("pre hlt", 0, 0, 0, 0, 1, 6, 0, 0);
    issue("hlt", 0, 0, 0, 0, 0, 0, 1, 0);
    chk("hlt halted", 32'(halted), 32'd1);
    drive(0, 1, 0, 1, 1, 9, 0);
    drain("hlt", WB_LAT - 1);
    chk("hlt ready", 32'(sb_if.issue_ready),
        32'd0);
    chk("hlt stall_cnt", 32'(stall_cnt),
        32'(WB_LAT - 1 - H));
    chk("hlt busy", busy_vec, 32'h0);
    pulse_flush();
    idle();
    chk("unhalt", 32'(halted), 32'd0);
    @(negedge clk);
    chk("unhalt ready",
        32'(sb_if.issue_ready), 32'd1);
    chk("unhalt stall", 32'(stall_cnt),
        32'd0);
    @(posedge clk);
    #1;

    drive(0, 1, 0, 1, 1, 9, 0);
    pulse_flush();
    idle();
    chk("flush prio", busy_vec, 32'h0);

    issue("r7", 0, 0, 0, 0, 1, 7, 0, 0);
    chk("r7 busy", busy_vec, 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async busy", busy_vec, 32'h0);
    chk("async drained", 32'(drained), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
